dme_range_tracker: RTL

//  Downstream of the receiver stage. Turns raw reply time (p1, in 1 us ticks) into a slant range.

---
 rtl/dme_range_tracker_pkg.sv | 20 ++
 rtl/dme_range_tracker_range_scaler.sv | 43 ++++
 rtl/dme_range_tracker.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dme_range_tracker_pkg.sv
// Shared types and fixed-point constants for the DME range tracker.
// Range scale: round trip is US_PER_NM_RT = 12.359 us per nautical mile.
package dme_range_tracker_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_MEMORY  = 2'd3
  } state_e;

  // round(2^16 / US_PER_NM_RT): turns Q12.4 microseconds into Q12.4 nautical miles
  localparam int unsigned K_NM_Q16 = 5303;

  localparam int EST_W      = 16;
  localparam int EST_FRAC_W = 4;
  localparam int R_W        = 12;
  localparam int K_W        = 13;

endpackage

// File: rtl/dme_range_tracker_range_scaler.sv
// Registered unsigned constant multiply followed by a truncating right shift.
// Loads only when asked; the strobe marks the cycle the new value appears.
module dme_range_tracker_range_scaler #(
  parameter int          IN_W  = 16,
  parameter int          K_W   = 13,
  parameter int unsigned K     = 5303,
  parameter int          SHIFT = 16,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IN_W-1:0]  value,
  output logic [OUT_W-1:0] scaled,
  output logic             strobe
);

  localparam int PROD_W = IN_W + K_W;
  localparam logic [PROD_W-1:0] K_EXT = PROD_W'(K);

  logic [PROD_W-1:0] prod;
  logic [OUT_W-1:0]  scaled_d, scaled_q;
  logic              strobe_q;

  always_comb begin
    prod     = PROD_W'(value) * K_EXT;
    scaled_d = load ? OUT_W'(prod >> SHIFT) : scaled_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scaled_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      scaled_q <= scaled_d;
      strobe_q <= load;
    end
  end

  assign scaled = scaled_q;
  assign strobe = strobe_q;

endmodule

// File: rtl/dme_range_tracker.sv
// DME slant-range tracker: reply-time qualification, gated acquire/track FSM,
// alpha-filtered Q12.4 estimate and scaling to Q12.4 nautical miles.
module dme_range_tracker
  import dme_range_tracker_pkg::*;
#(
  parameter int unsigned REPLY_DELAY_US = 50,
  parameter int unsigned MAX_RANGE_US   = 2472,
  parameter int unsigned GATE_US        = 20,
  parameter int unsigned ACQ_HITS       = 4,
  parameter int unsigned MISS_LIMIT     = 8,
  parameter int unsigned TIMEOUT_CYC    = 40000,
  parameter int unsigned ALPHA_SHIFT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] p1,
  input  logic        p1_valid,
  output logic [15:0] range_nm,
  output logic        range_update,
  output logic        range_valid,
  output logic        locked,
  output logic [1:0]  state_dbg
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYC);
  localparam int HITS_W = $clog2(ACQ_HITS + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam int GAP_W  = R_W + 1;
  localparam int SUM_W  = EST_W + 2;

  localparam logic [R_W-1:0]          DELAY      = R_W'(REPLY_DELAY_US);
  localparam logic [R_W-1:0]          MAX_R      = R_W'(MAX_RANGE_US);
  localparam logic [GAP_W-1:0]        GATE       = GAP_W'(GATE_US);
  localparam logic [TMO_W-1:0]        TMO_RELOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [HITS_W-1:0]       HITS_LOCK  = HITS_W'(ACQ_HITS);
  localparam logic [MISS_W-1:0]       MISS_MAX   = MISS_W'(MISS_LIMIT);
  localparam logic signed [SUM_W-1:0] EST_MAX    = SUM_W'(MAX_RANGE_US << EST_FRAC_W);

  function automatic logic [EST_W-1:0] sat_est(input logic signed [SUM_W-1:0] v);
    logic [EST_W-1:0] res;
    if (v < 0)            res = '0;
    else if (v > EST_MAX) res = EST_MAX[EST_W-1:0];
    else                  res = v[EST_W-1:0];
    return res;
  endfunction

  function automatic logic [EST_W-1:0] alpha_step(input logic [EST_W-1:0] est,
                                                  input logic [R_W-1:0]   r);
    logic signed [SUM_W-1:0] target, cur, delta, sum;
    target = $signed({2'b00, r, {EST_FRAC_W{1'b0}}});
    cur    = $signed({2'b00, est});
    delta  = target - cur;
    sum    = cur + (delta >>> ALPHA_SHIFT);
    return sat_est(sum);
  endfunction

  logic               p1v_low_q;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               vld_p0_d, rej_p0_d, tmo_p0_d, acc_p0;
  logic [R_W-1:0]     r_p0_d;
  logic               vld_p0_q, rej_p0_q, tmo_p0_q;
  logic [R_W-1:0]     r_p0_q;

  logic [R_W-1:0]          est_int;
  logic signed [GAP_W-1:0] diff;
  logic [GAP_W-1:0]        gap;
  logic                    good, in_gate, miss;
  logic [EST_W-1:0]        r_q4, est_filt;

  state_e              state_q, state_d;
  logic [EST_W-1:0]    est_q, est_d;
  logic [HITS_W-1:0]   hits_q, hits_d;
  logic [MISS_W-1:0]   misses_q, misses_d;
  logic                upd_p1_q, upd_p1_d;

  // Stage 0: edge detect, delay removal, plausibility check, reply timeout.
  // p1v_low_q means "p1_valid was low last cycle"; clearing it on reset stops
  // a level held high through reset from looking like a fresh edge.
  always_comb begin
    vld_p0_d  = p1_valid & p1v_low_q;
    r_p0_d    = p1[R_W-1:0] - DELAY;
    rej_p0_d  = (|p1[31:R_W]) | (p1[R_W-1:0] < DELAY) | (r_p0_d > MAX_R);
    acc_p0    = vld_p0_d & ~rej_p0_d;
    tmo_p0_d  = (tmo_cnt_q == '0) & ~acc_p0;
    tmo_cnt_d = (acc_p0 || tmo_cnt_q == '0) ? TMO_RELOAD : tmo_cnt_q - TMO_W'(1);
  end

  // Stage 1: gate test against the current estimate, FSM and estimate update.
  always_comb begin
    est_int  = est_q[EST_W-1:EST_FRAC_W];
    diff     = $signed({1'b0, r_p0_q}) - $signed({1'b0, est_int});
    gap      = diff[GAP_W-1] ? GAP_W'(-diff) : GAP_W'(diff);
    good     = vld_p0_q & ~rej_p0_q;
    in_gate  = good & (gap <= GATE);
    miss     = (vld_p0_q & ~in_gate) | tmo_p0_q;
    r_q4     = {r_p0_q, {EST_FRAC_W{1'b0}}};
    est_filt = alpha_step(est_q, r_p0_q);
  end

  always_comb begin
    state_d  = state_q;
    est_d    = est_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    upd_p1_d = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (good) begin
          est_d   = r_q4;
          hits_d  = HITS_W'(1);
          state_d = ST_ACQUIRE;
        end
      end
      ST_ACQUIRE: begin
        if (in_gate) begin
          est_d  = r_q4;
          hits_d = hits_q + HITS_W'(1);
          if (hits_q + HITS_W'(1) == HITS_LOCK) begin
            state_d  = ST_TRACK;
            upd_p1_d = 1'b1;
          end
        end else if (vld_p0_q) begin
          if (good) est_d = r_q4;
          hits_d = HITS_W'(1);
        end else if (tmo_p0_q) begin
          state_d = ST_SEARCH;
        end
      end
      ST_TRACK: begin
        if (in_gate) begin
          est_d    = est_filt;
          upd_p1_d = 1'b1;
        end else if (miss) begin
          misses_d = MISS_W'(1);
          state_d  = ST_MEMORY;
        end
      end
      default: begin
        if (in_gate) begin
          est_d    = est_filt;
          misses_d = '0;
          upd_p1_d = 1'b1;
          state_d  = ST_TRACK;
        end else if (miss) begin
          if (misses_q + MISS_W'(1) == MISS_MAX) begin
            misses_d = '0;
            state_d  = ST_SEARCH;
          end else begin
            misses_d = misses_q + MISS_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1v_low_q <= 1'b0;
      tmo_cnt_q <= TMO_RELOAD;
      vld_p0_q  <= 1'b0;
      rej_p0_q  <= 1'b0;
      tmo_p0_q  <= 1'b0;
      state_q   <= ST_SEARCH;
      est_q     <= '0;
      hits_q    <= '0;
      misses_q  <= '0;
      upd_p1_q  <= 1'b0;
    end else begin
      p1v_low_q <= ~p1_valid;
      tmo_cnt_q <= tmo_cnt_d;
      vld_p0_q  <= vld_p0_d;
      rej_p0_q  <= rej_p0_d;
      tmo_p0_q  <= tmo_p0_d;
      state_q   <= state_d;
      est_q     <= est_d;
      hits_q    <= hits_d;
      misses_q  <= misses_d;
      upd_p1_q  <= upd_p1_d;
    end
  end

  always_ff @(posedge clk) begin
    r_p0_q <= r_p0_d;
  end

  // Stage 2: scale the estimate to nautical miles.
  dme_range_tracker_range_scaler #(
    .IN_W  (EST_W),
    .K_W   (K_W),
    .K     (K_NM_Q16),
    .SHIFT (16),
    .OUT_W (16)
  ) u_scaler (
    .clk    (clk),
    .rst    (reset),
    .load   (upd_p1_q),
    .value  (est_q),
    .scaled (range_nm),
    .strobe (range_update)
  );

  assign range_valid = (state_q == ST_TRACK) || (state_q == ST_MEMORY);
  assign locked      = (state_q == ST_TRACK);
  assign state_dbg   = state_q;

endmodule
